// File: rtl/uart_frame_decoder_if.sv
// Byte stream between the serial receiver, the frame decoder and the command logic.
// The decoder uses the slave view; whoever feeds it uses the master view.
interface uart_frame_decoder_if;
  logic       rcv;
  logic [7:0] data;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       frame_ok;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic       err_overrun;

  modport master (
    output rcv, data, out_ready,
    input  out_data, out_valid, out_last, frame_ok,
    input  err_len, err_chk, err_timeout, err_overrun
  );

  modport slave (
    input  rcv, data, out_ready,
    output out_data, out_valid, out_last, frame_ok,
    output err_len, err_chk, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Hunts for SOF, buffers a length-prefixed payload, verifies its XOR checksum and
// replays good payloads on a valid/ready stream; status is reported as one-cycle pulses.
module uart_frame_decoder #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'h7E,
  parameter int         TIMEOUT = 120000
) (
  input logic                 clk,
  input logic                 rstn,
  uart_frame_decoder_if.slave bus
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [IW-1:0] len_r;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] rd_idx_r;
  logic [7:0]    chk_r;
  logic [CW-1:0] cnt_r;
  logic [7:0]    pay_buf_r [0:(1<<AW)-1];

  logic frame_ok_r, err_len_r, err_chk_r, err_timeout_r, err_overrun_r;
  logic frame_ok_s, err_len_s, err_chk_s, err_timeout_s, err_overrun_s;
  logic len_bad_s, last_s, hs_s, cnt_hit_s, in_frame_s;

  assign len_bad_s  = (bus.data == 8'h00) || (bus.data > LEN_MAX);
  assign last_s     = (rd_idx_r == len_r - IW'(1));
  assign hs_s       = (state_r == SEND) && bus.out_ready;
  assign cnt_hit_s  = (cnt_r == CNT_LAST);
  assign in_frame_s = (state_r == LEN) || (state_r == PAYLOAD) || (state_r == CHK);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and status pulse requests; a byte strobe always beats the timeout
  always_comb begin
    state_next_s  = state_r;
    frame_ok_s    = 1'b0;
    err_len_s     = 1'b0;
    err_chk_s     = 1'b0;
    err_timeout_s = 1'b0;
    err_overrun_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (bus.rcv && (bus.data == SOF)) state_next_s = LEN;
        else                              state_next_s = HUNT;
      end
      LEN: begin
        if (bus.rcv) begin
          if (len_bad_s) begin
            err_len_s    = 1'b1;
            state_next_s = HUNT;
          end else begin
            state_next_s = PAYLOAD;
          end
        end else if (cnt_hit_s) begin
          err_timeout_s = 1'b1;
          state_next_s  = HUNT;
        end else begin
          state_next_s = LEN;
        end
      end
      PAYLOAD: begin
        if (bus.rcv) begin
          if (idx_r == len_r - IW'(1)) state_next_s = CHK;
          else                         state_next_s = PAYLOAD;
        end else if (cnt_hit_s) begin
          err_timeout_s = 1'b1;
          state_next_s  = HUNT;
        end else begin
          state_next_s = PAYLOAD;
        end
      end
      CHK: begin
        if (bus.rcv) begin
          if (bus.data == chk_r) begin
            frame_ok_s   = 1'b1;
            state_next_s = SEND;
          end else begin
            err_chk_s    = 1'b1;
            state_next_s = HUNT;
          end
        end else if (cnt_hit_s) begin
          err_timeout_s = 1'b1;
          state_next_s  = HUNT;
        end else begin
          state_next_s = CHK;
        end
      end
      SEND: begin
        err_overrun_s = bus.rcv;
        if (hs_s && last_s) state_next_s = HUNT;
        else                state_next_s = SEND;
      end
      default: begin
        state_next_s = HUNT;
      end
    endcase
  end

  // Frame bookkeeping, inter-byte timer and registered status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_r         <= '0;
      idx_r         <= '0;
      rd_idx_r      <= '0;
      chk_r         <= 8'h00;
      cnt_r         <= '0;
      frame_ok_r    <= 1'b0;
      err_len_r     <= 1'b0;
      err_chk_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      frame_ok_r    <= frame_ok_s;
      err_len_r     <= err_len_s;
      err_chk_r     <= err_chk_s;
      err_timeout_r <= err_timeout_s;
      err_overrun_r <= err_overrun_s;
      if (in_frame_s && !bus.rcv && !cnt_hit_s) cnt_r <= cnt_r + CW'(1);
      else                                      cnt_r <= '0;
      case (state_r)
        LEN: begin
          if (bus.rcv && !len_bad_s) begin
            len_r <= bus.data[IW-1:0];
            chk_r <= bus.data;
            idx_r <= '0;
          end
        end
        PAYLOAD: begin
          if (bus.rcv) begin
            chk_r <= chk_r ^ bus.data;
            idx_r <= idx_r + IW'(1);
          end
        end
        CHK: begin
          if (bus.rcv && (bus.data == chk_r)) rd_idx_r <= '0;
        end
        SEND: begin
          if (hs_s && !last_s) rd_idx_r <= rd_idx_r + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Payload storage; contents are only observed in SEND, so it carries no reset
  always_ff @(posedge clk) begin
    if ((state_r == PAYLOAD) && bus.rcv) pay_buf_r[idx_r[AW-1:0]] <= bus.data;
  end

  assign bus.out_valid   = (state_r == SEND);
  assign bus.out_data    = (state_r == SEND) ? pay_buf_r[rd_idx_r[AW-1:0]] : 8'h00;
  assign bus.out_last    = (state_r == SEND) && last_s;
  assign bus.frame_ok    = frame_ok_r;
  assign bus.err_len     = err_len_r;
  assign bus.err_chk     = err_chk_r;
  assign bus.err_timeout = err_timeout_r;
  assign bus.err_overrun = err_overrun_r;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: table of byte sequences, directed corner sequences,
// then random frames scored against a frame-level reference model.
module tb_uart_frame_decoder;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 30;
  localparam logic [7:0] SOF     = 8'h7E;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_frame_decoder_if bus();
  uart_frame_decoder #(.MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct {
    int         n;
    logic [7:0] b [0:19];
    logic [4:0] pulse;       // {frame_ok, err_len, err_chk, err_timeout, err_overrun}
    int         nout;
    logic [7:0] o [0:15];
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } out_t;

  vec_t vt [0:6];
  out_t exp_q [$];
  int checks = 0;
  int errors = 0;
  int got_ok, got_len, got_chk, got_to, got_ovr;
  int exp_ok, exp_len, exp_chk;
  logic       stall_pending = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pulses();
    return {bus.frame_ok, bus.err_len, bus.err_chk, bus.err_timeout, bus.err_overrun};
  endfunction

  task automatic check_pulses(input string tag, input logic [4:0] exp);
    check({tag, "_pulses"}, 32'(pulses()), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {bus.out_data, bus.out_valid, bus.out_last, pulses()}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rcv  = 1'b1;
    bus.data = b;
    tick();
    bus.rcv  = 1'b0;
    bus.data = 8'($urandom);
  endtask

  task automatic expect_payload(input string tag, input logic [7:0] p[$]);
    bus.out_ready = 1'b1;
    for (int j = 0; j < p.size(); j++) begin
      check($sformatf("%s_valid%0d", tag, j), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, j), 32'(bus.out_data), 32'(p[j]));
      check($sformatf("%s_last%0d", tag, j), 32'(bus.out_last), 32'(j == p.size() - 1));
      tick();
    end
    check({tag, "_idle"}, {bus.out_data, bus.out_valid}, 32'd0);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] p[$]);
    logic [7:0] x;
    x = 8'(p.size());
    send_byte(SOF);
    send_byte(x);
    foreach (p[k]) begin
      send_byte(p[k]);
      x ^= p[k];
    end
    send_byte(x);
    check_pulses(tag, 5'b10000);
    expect_payload(tag, p);
  endtask

  task automatic set_vec(input int v, input logic [7:0] bq[$], input logic [4:0] p,
                         input logic [7:0] oq[$]);
    vt[v].n     = bq.size();
    vt[v].pulse = p;
    vt[v].nout  = oq.size();
    foreach (bq[k]) vt[v].b[k] = bq[k];
    foreach (oq[k]) vt[v].o[k] = oq[k];
  endtask

  // Frame-level reference: applies the framing rules to a whole byte list at once
  task automatic model(input logic [7:0] q[$]);
    int i;
    int len;
    logic [7:0] x;
    out_t e;
    i = 0;
    while (i < q.size() && q[i] != SOF) i++;
    if (i + 1 >= q.size()) return;
    len = int'(q[i+1]);
    if (len == 0 || len > MAX_LEN) begin
      exp_len++;
      return;
    end
    x = q[i+1];
    for (int k = 0; k < len; k++) x ^= q[i+2+k];
    if (q[i+2+len] == x) begin
      exp_ok++;
      for (int k = 0; k < len; k++) begin
        e.data = q[i+2+k];
        e.last = (k == len - 1);
        exp_q.push_back(e);
      end
    end else begin
      exp_chk++;
    end
  endtask

  task automatic step();
    out_t e;
    bus.out_ready = ($urandom_range(0, 3) != 0);
    if (bus.frame_ok)    got_ok++;
    if (bus.err_len)     got_len++;
    if (bus.err_chk)     got_chk++;
    if (bus.err_timeout) got_to++;
    if (bus.err_overrun) got_ovr++;
    if (stall_pending) begin
      check("stall_data", 32'(bus.out_data), 32'(stall_data));
      check("stall_last", 32'(bus.out_last), 32'(stall_last));
    end
    stall_pending = bus.out_valid && !bus.out_ready;
    stall_data    = bus.out_data;
    stall_last    = bus.out_last;
    if (!bus.out_valid) begin
      check("rnd_idle_zero", {bus.out_data, bus.out_last}, 32'd0);
    end else if (bus.out_ready) begin
      check("rnd_out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rnd_data", 32'(bus.out_data), 32'(e.data));
        check("rnd_last", 32'(bus.out_last), 32'(e.last));
      end
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq [$];
    logic [7:0] oq [$];
    logic [7:0] fq [$];
    logic [7:0] b, x;
    int kind, len, g, n;

    bus.rcv = 1'b0;
    bus.data = 8'h00;
    bus.out_ready = 1'b1;

    bq = '{8'h00, 8'hFF, 8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    oq = '{8'h11, 8'h22, 8'h33};
    set_vec(0, bq, 5'b10000, oq);
    bq = '{8'h7E, 8'h02, 8'hAA, 8'h55, 8'h00};
    oq.delete();
    set_vec(1, bq, 5'b00100, oq);
    bq = '{8'h7E, 8'h00};
    set_vec(2, bq, 5'b01000, oq);
    bq = '{8'h7E, 8'h11};
    set_vec(3, bq, 5'b01000, oq);
    bq = '{8'h7E, 8'h01, 8'h7E, 8'h7F};
    oq = '{8'h7E};
    set_vec(4, bq, 5'b10000, oq);
    bq = '{8'h7E, 8'h10};
    oq.delete();
    for (int k = 0; k < 16; k++) begin
      bq.push_back(8'(k));
      oq.push_back(8'(k));
    end
    bq.push_back(8'h10);
    set_vec(5, bq, 5'b10000, oq);
    bq = '{8'h7E, 8'h01, 8'hFF, 8'hFE};
    oq = '{8'hFF};
    set_vec(6, bq, 5'b10000, oq);

    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();
    check_all_zero("post_reset");

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vt[v].n; k++) begin
        send_byte(vt[v].b[k]);
        check_pulses($sformatf("vec%0d_b%0d", v, k), (k == vt[v].n - 1) ? vt[v].pulse : 5'b0);
      end
      for (int j = 0; j < vt[v].nout; j++) begin
        check($sformatf("vec%0d_valid%0d", v, j), 32'(bus.out_valid), 32'd1);
        check($sformatf("vec%0d_data%0d", v, j), 32'(bus.out_data), 32'(vt[v].o[j]));
        check($sformatf("vec%0d_last%0d", v, j), 32'(bus.out_last), 32'(j == vt[v].nout - 1));
        tick();
      end
      check($sformatf("vec%0d_idle", v), {bus.out_data, bus.out_valid}, 32'd0);
    end

    // Timeout fires exactly TIMEOUT edges after the last byte
    send_byte(SOF);
    send_byte(8'h02);
    send_byte(8'hAA);
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      tick();
      check_pulses($sformatf("to_%0d", k), (k == TIMEOUT) ? 5'b00010 : 5'b0);
    end
    bq = '{8'h5A, 8'hC3};
    good_frame("after_to", bq);

    // A byte landing on the would-be timeout edge wins
    send_byte(SOF);
    send_byte(8'h02);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'hAA);
    check_pulses("race1", 5'b0);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'hBB);
    check_pulses("race2", 5'b0);
    send_byte(8'h13);
    check_pulses("race_chk", 5'b10000);
    bq = '{8'hAA, 8'hBB};
    expect_payload("race", bq);

    // Backpressure with an SOF dropped during SEND
    bus.out_ready = 1'b0;
    bq = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    foreach (bq[k]) send_byte(bq[k]);
    for (int i = 0; i < 5; i++) begin
      check_pulses($sformatf("bp%0d", i), (i == 0) ? 5'b10000 : ((i == 2) ? 5'b00001 : 5'b0));
      check($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_data%0d", i), 32'(bus.out_data), 32'h11);
      check($sformatf("bp_last%0d", i), 32'(bus.out_last), 32'd0);
      if (i == 1) begin
        bus.rcv  = 1'b1;
        bus.data = SOF;
      end
      tick();
      bus.rcv = 1'b0;
    end
    bq = '{8'h11, 8'h22, 8'h33};
    expect_payload("bp", bq);
    bq = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    foreach (bq[k]) begin
      send_byte(bq[k]);
      check_pulses($sformatf("bp_nosof%0d", k), 5'b0);
    end

    // Overrun on the final handshake cycle
    send_byte(SOF);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h54);
    check("ovl_last", {bus.out_valid, bus.out_last, bus.out_data}, {2'b11, 8'h55});
    bus.rcv  = 1'b1;
    bus.data = SOF;
    tick();
    bus.rcv  = 1'b0;
    check_pulses("ovl_ovr", 5'b00001);
    check("ovl_idle", 32'(bus.out_valid), 32'd0);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h54);
    check_pulses("ovl_nosof", 5'b0);

    // Reset mid-SEND (asynchronous) and mid-PAYLOAD
    bus.out_ready = 1'b0;
    bq = '{8'h7E, 8'h02, 8'h10, 8'h20, 8'h32};
    foreach (bq[k]) send_byte(bq[k]);
    check("rs_send_valid", 32'(bus.out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1 check_all_zero("rs_send_async");
    tick();
    check_all_zero("rs_send_held");
    rstn = 1'b1;
    bq = '{8'hDE, 8'hAD, 8'hBE};
    good_frame("rs_send_after", bq);
    send_byte(SOF);
    send_byte(8'h03);
    send_byte(8'h11);
    rstn = 1'b0;
    tick();
    check_all_zero("rs_pay");
    rstn = 1'b1;
    bq = '{8'h22, 8'h33, 8'h03};
    foreach (bq[k]) begin
      send_byte(bq[k]);
      check_pulses($sformatf("rs_pay_discard%0d", k), 5'b0);
    end
    check("rs_pay_idle", 32'(bus.out_valid), 32'd0);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    good_frame("rs_pay_after", bq);

    // Random frames against the reference model
    got_ok = 0; got_len = 0; got_chk = 0; got_to = 0; got_ovr = 0;
    exp_ok = 0; exp_len = 0; exp_chk = 0;
    for (int f = 0; f < 60; f++) begin
      fq.delete();
      g = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      if (kind == 9 && g == 0) g = 1;
      repeat (g) begin
        b = 8'($urandom_range(0, 254));
        if (b >= SOF) b++;
        fq.push_back(b);
      end
      if (kind <= 7) begin
        len = $urandom_range(1, MAX_LEN);
        fq.push_back(SOF);
        fq.push_back(8'(len));
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          x ^= b;
          fq.push_back(b);
        end
        if (kind >= 6) x ^= 8'($urandom_range(1, 255));
        fq.push_back(x);
      end else if (kind == 8) begin
        fq.push_back(SOF);
        fq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end
      model(fq);
      foreach (fq[k]) begin
        repeat ($urandom_range(0, 2)) step();
        bus.rcv  = 1'b1;
        bus.data = fq[k];
        step();
        bus.rcv  = 1'b0;
        bus.data = 8'($urandom);
      end
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin
        step();
        n++;
      end
      check($sformatf("rnd_drain%0d", f), 32'(exp_q.size()), 32'd0);
    end
    repeat (3) step();
    check("rnd_frame_ok", 32'(got_ok), 32'(exp_ok));
    check("rnd_err_len", 32'(got_len), 32'(exp_len));
    check("rnd_err_chk", 32'(got_chk), 32'(exp_chk));
    check("rnd_err_timeout", 32'(got_to), 32'd0);
    check("rnd_err_overrun", 32'(got_ovr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-framing stage directly downstream of the serial receiver. Consumes its one-cycle `rcv` strobe and `data` byte, hunts for a start-of-frame marker, and collects a length-prefixed payload into an internal buffer. The block checks an XOR checksum and, only for valid frames, replays the payload on a valid/ready byte stream to the command logic. Malformed, truncated or overrun traffic is reported on one-cycle error strobes.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes (1..255); sets buffer depth.
- `SOF`, 8'h7E: start-of-frame byte value.
- `TIMEOUT`, 120000: idle clock cycles allowed between bytes inside a frame (10 ms at 12 MHz).
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rcv`  in  1  one-cycle strobe: `data` holds a new byte.
- `data`  in  8  received byte, valid when `rcv`=1.
- `out_data`  out  8  payload byte; forced to 0 when `out_valid`=0.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte this cycle.
- `out_last`  out  1  current byte is the final payload byte (qualified by `out_valid`).
- `frame_ok`  out  1  one-cycle pulse: a frame passed the checksum.
- `err_len`  out  1  one-cycle pulse: the length byte was 0 or greater than `MAX_LEN`.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout inside a frame.
- `err_overrun`  out  1  one-cycle pulse: a byte arrived while a frame was being sent and was dropped.

## Operation
- Frame format: `SOF`, `LEN`, `LEN` payload bytes, `CHK`. `CHK` = XOR of `LEN` and all payload bytes.
- The FSM has states HUNT, LEN, PAYLOAD, CHK and SEND. It acts only on cycles where `rcv`=1, except in SEND and on timeout.
- HUNT: a byte equal to `SOF` moves to LEN. All other bytes are silently ignored.
- LEN: if the byte is 0 or greater than `MAX_LEN`, pulse `err_len` and go to HUNT. Otherwise latch `len`, set `chk`=byte and `idx`=0, then go to PAYLOAD.
- PAYLOAD: write `buf[idx]`=byte, set `chk`^=byte and increment `idx`. After the write at `idx`=`len`-1, go to CHK.
- PAYLOAD has no SOF re-synchronisation: a payload byte equal to `SOF` is stored as ordinary data.
- CHK: if the byte equals `chk`, pulse `frame_ok`, set `rd_idx`=0 and go to SEND. Otherwise pulse `err_chk` and go to HUNT; nothing is output.
- SEND: `out_valid`=1, `out_data`=`buf[rd_idx]`, `out_last`=(`rd_idx`==`len`-1).
  - When `out_valid` and `out_ready` are both 1: if `out_last`, go to HUNT; otherwise increment `rd_idx`.
- Any `rcv` in SEND, including an `SOF` byte, is dropped and pulses `err_overrun`. The frame in progress continues unaffected.
- Timeout: a cycle counter of width $clog2(TIMEOUT+1) runs in LEN, PAYLOAD and CHK.
  - It clears on every `rcv` and on entry to LEN.
  - When it reaches `TIMEOUT`, pulse `err_timeout` and go to HUNT. If `rcv` arrives in the same cycle, `rcv` wins and the counter clears.
  - The counter is held at 0 in HUNT and SEND.
- The checksum register is 8 bits wide. Indices are $clog2(MAX_LEN+1) bits wide. The buffer is not reset.

## Timing
- Reset (`rstn`=0, any time, including mid-frame or mid-SEND):
  - state becomes HUNT and the counters clear;
  - `out_valid`, `out_last`, `out_data`, `frame_ok` and all `err_*` outputs are 0 immediately;
  - a partial frame is discarded.
- All outputs are registered or decoded from registered state. There is no combinational path from `rcv` or `data` to any output.
- Status pulses are high for exactly one cycle: the cycle after the clock edge that sampled the triggering `rcv`, or after the edge at which the timeout was reached.
- `frame_ok` is high in the first SEND cycle. `out_valid` rises in that same cycle, one cycle after the `CHK` byte's `rcv`.
- Stall: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.
- Throughput: 1 byte per cycle when `out_ready` is held at 1. The frame's last handshake cycle is followed by 1 cycle in HUNT before the next `SOF` can be taken.
- A `rcv` in the final SEND handshake cycle still counts as an overrun.

## Test plan
- Good frame 7E 03 11 22 33 03, with garbage bytes 00 FF before it:
  - required: `frame_ok` one cycle;
  - `out_data` 11, 22, 33 over 3 consecutive cycles with `out_ready`=1;
  - `out_last` high only on 33;
  - no error pulses.
- Bad checksum 7E 02 AA 55 00 (expected FD): required `err_chk` one cycle, `out_valid` never high. A following good frame decodes correctly.
- Length errors 7E 00 and 7E 11 with `MAX_LEN`=16: required `err_len` after each; the decoder returns to HUNT.
- Timeout: 7E 02 AA, then `TIMEOUT` idle cycles. Required: `err_timeout` exactly once, at cycle `TIMEOUT` after the AA strobe. A subsequent good frame decodes.
- Backpressure and overrun: good 3-byte frame with `out_ready` low for 5 cycles, and a `rcv` of 7E injected during SEND. Required:
  - `out_data`=11 held for the 5 cycles;
  - `err_overrun` pulse;
  - the full payload is still delivered and no new frame is started.
- Reset mid-SEND and mid-PAYLOAD: required all outputs 0 during reset; after release, a fresh good frame decodes correctly.
